// File: rtl/uwasic_onboarding_alex_js_if.sv
// Pin bundle of the onboarding tile.
// The tile drives uo/uio/oe; the harness drives ui/uio_in/ena.
interface uwasic_onboarding_alex_js_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/uwasic_onboarding_alex_js.sv
// SPI-programmed 16-channel PWM/GPIO tile.
// Write-only mode-0 SPI loads five control registers.
module uwasic_onboarding_alex_js (
  input  logic clk,
  input  logic rst_n,
  uwasic_onboarding_alex_js_if.slave bus
);

  logic [1:0]  sclk_s, copi_s, ncs_s;
  logic        sclk_q, ncs_q;
  logic        sclk_rise, ncs_fall, ncs_rise;
  logic [15:0] shift;
  logic [4:0]  nbits;
  logic [2:0]  addr;
  logic [7:0]  data;
  logic        commit;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [3:0]  pre;
  logic [7:0]  cnt;
  logic        pwm;
  logic [15:0] out;
  logic        unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 2'b00;
      copi_s <= 2'b00;
      ncs_s  <= 2'b11;
      sclk_q <= 1'b0;
      ncs_q  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], bus.ui_in[0]};
      copi_s <= {copi_s[0], bus.ui_in[1]};
      ncs_s  <= {ncs_s[0], bus.ui_in[2]};
      sclk_q <= sclk_s[1];
      ncs_q  <= ncs_s[1];
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_q;
  assign ncs_fall  = ~ncs_s[1] & ncs_q;
  assign ncs_rise  = ncs_s[1] & ~ncs_q;

  // Bit count saturates so over-long frames never alias to 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      nbits <= '0;
    end else if (ncs_fall) begin
      shift <= '0;
      nbits <= '0;
    end else if (sclk_rise && !ncs_s[1]) begin
      shift <= {shift[14:0], copi_s[1]};
      if (nbits != 5'd31)
        nbits <= nbits + 5'd1;
    end
  end

  assign addr   = shift[10:8];
  assign data   = shift[7:0];
  assign commit = ncs_rise
                & (nbits == 5'd16)
                & shift[15]
                & (shift[14:8] <= 7'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= '0;
      en_pwm <= '0;
      duty   <= '0;
    end else if (commit) begin
      unique case (1'b1)
        (addr == 3'd0): en_out[7:0]  <= data;
        (addr == 3'd1): en_out[15:8] <= data;
        (addr == 3'd2): en_pwm[7:0]  <= data;
        (addr == 3'd3): en_pwm[15:8] <= data;
        (addr == 3'd4): duty         <= data;
        default: ;
      endcase
    end
  end

  // 13-cycle prescaler x 256 steps gives ~3 kHz at 10 MHz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (pre == 4'd12) begin
      pre <= '0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + 4'd1;
    end
  end

  assign pwm = (duty == 8'hFF) | (cnt < duty);
  assign out = en_out & (~en_pwm | {16{pwm}});

  assign bus.uo_out  = out[7:0];
  assign bus.uio_out = out[15:8];
  assign bus.uio_oe  = 8'hFF;

  assign unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_alex_js.sv
// Bench for the SPI PWM/GPIO tile: scoreboard for static pins,
// direct measurements for PWM timing.
module tb_uwasic_onboarding_alex_js;

  logic clk;
  logic rst_n;

  uwasic_onboarding_alex_js_if bus();

  uwasic_onboarding_alex_js dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uo_mask;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors;
  int   miscompares;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (((bus.uo_out & e.uo_mask) !== (e.uo & e.uo_mask)) ||
          (bus.uio_out !== e.uio) || (bus.uio_oe !== 8'hFF)) begin
        miscompares++;
        $display("FAIL %s: got uo=%h uio=%h oe=%h want uo=%h/%h uio=%h oe=ff",
                 e.name, bus.uo_out, bus.uio_out, bus.uio_oe,
                 e.uo, e.uo_mask, e.uio);
      end
    end
  end

  task automatic expect_pins(input string n, input logic [7:0] uo,
                             input logic [7:0] m, input logic [7:0] uio);
    exp_t x;
    x.name = n;
    x.uo = uo;
    x.uo_mask = m;
    x.uio = uio;
    sb.push_back(x);
  endtask

  task automatic chk(input string n, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d..%0d", n, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [31:0] bits, input int n);
    bus.ui_in[2] = 1'b0;
    idle(4);
    for (int i = n - 1; i >= 0; i--) begin
      bus.ui_in[1] = bits[i];
      idle(4);
      bus.ui_in[0] = 1'b1;
      idle(4);
      bus.ui_in[0] = 1'b0;
    end
    idle(4);
    bus.ui_in[2] = 1'b1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    frame({16'h0, 1'b1, a, d}, 16);
    idle(8);
  endtask

  task automatic measure(output int hi, output int per);
    int   t;
    int   lo;
    logic prev;
    hi = 0;
    lo = 0;
    t = 0;
    do begin
      prev = bus.uo_out[0];
      @(negedge clk);
      t++;
    end while (!(prev == 1'b0 && bus.uo_out[0] == 1'b1) && t < 4000);
    if (t >= 4000) begin
      hi = -1;
      per = -1;
      return;
    end
    while (bus.uo_out[0] == 1'b1 && hi < 4000) begin
      hi++;
      @(negedge clk);
    end
    while (bus.uo_out[0] == 1'b0 && lo < 4000) begin
      lo++;
      @(negedge clk);
    end
    per = hi + lo;
  endtask

  task automatic count_bit0(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.uo_out[0]) ones++;
    end
  endtask

  int hi, per, ones;
  int hcnt[4];
  int bad;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.ui_in = 8'b0000_0100;
    bus.uio_in = 8'h00;
    idle(5);
    rst_n = 1'b1;
    idle(1);
    expect_pins("reset", 8'h00, 8'hFF, 8'h00);

    wr(7'h00, 8'hF0);
    wr(7'h01, 8'hCC);
    expect_pins("static", 8'hF0, 8'hFF, 8'hCC);

    wr(7'h30, 8'hAA);
    expect_pins("bad_addr_30", 8'hF0, 8'hFF, 8'hCC);
    wr(7'h08, 8'hAA);
    expect_pins("bad_addr_08", 8'hF0, 8'hFF, 8'hCC);
    wr(7'h05, 8'h55);
    expect_pins("bad_addr_05", 8'hF0, 8'hFF, 8'hCC);
    frame(32'h0000_0055, 16);
    idle(8);
    expect_pins("read_frame", 8'hF0, 8'hFF, 8'hCC);
    frame(32'h0000_0801, 12);
    idle(8);
    expect_pins("short_frame", 8'hF0, 8'hFF, 8'hCC);
    frame(32'h0000_8000, 17);
    idle(8);
    expect_pins("long_frame", 8'hF0, 8'hFF, 8'hCC);
    frame(32'h0, 0);
    idle(8);
    expect_pins("empty_frame", 8'hF0, 8'hFF, 8'hCC);

    frame(32'h0000_805A, 16);
    idle(2);
    expect_pins("latency_2", 8'hF0, 8'hFF, 8'hCC);
    idle(1);
    expect_pins("latency_3", 8'h5A, 8'hFF, 8'hCC);
    idle(8);

    bus.ui_in[2] = 1'b0;
    idle(4);
    for (int i = 0; i < 10; i++) begin
      bus.ui_in[1] = 1'b1;
      idle(4);
      bus.ui_in[0] = 1'b1;
      idle(4);
      bus.ui_in[0] = 1'b0;
    end
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    bus.ui_in[2] = 1'b1;
    idle(8);
    expect_pins("reset_abort", 8'h00, 8'hFF, 8'h00);

    wr(7'h00, 8'h01);
    expect_pins("gpio_bit0", 8'h01, 8'hFF, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h04, 8'h80);
    measure(hi, per);
    chk("pwm50_period", per, 3327, 3329);
    chk("pwm50_high", hi, 1651, 1677);

    wr(7'h04, 8'h00);
    count_bit0(6656, ones);
    chk("duty00_ones", ones, 0, 0);

    wr(7'h04, 8'hFF);
    count_bit0(6656, ones);
    chk("dutyFF_ones", ones, 6656, 6656);

    wr(7'h00, 8'hFF);
    wr(7'h01, 8'h3C);
    wr(7'h03, 8'h00);
    wr(7'h02, 8'h0F);
    wr(7'h04, 8'h40);
    expect_pins("mixed_static", 8'hF0, 8'hF0, 8'h3C);
    bad = 0;
    for (int b = 0; b < 4; b++) hcnt[b] = 0;
    for (int i = 0; i < 3328; i++) begin
      @(negedge clk);
      if (bus.uo_out[7:4] != 4'hF) bad++;
      for (int b = 0; b < 4; b++)
        if (bus.uo_out[b]) hcnt[b]++;
    end
    chk("mixed_hi_nibble", bad, 0, 0);
    for (int b = 0; b < 4; b++)
      chk($sformatf("mixed_bit%0d_high", b), hcnt[b], 831, 833);

    idle(4);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uwasic_onboarding_alex_js.md
# uwasic_onboarding_alex_js

SPI-programmable 16-channel PWM/GPIO output block, the top-level user tile of the onboarding chip. A write-only SPI peripheral (mode 0) on the dedicated inputs loads five 8-bit control registers. A shared ~3 kHz PWM generator drives 16 outputs: 8 on uo_out and 8 on the bidirectional pins, which are always driven as outputs.

## Interface
- No parameters. Clock is nominally 10 MHz; register map and PWM divider are fixed.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; clears all registers and synchronizers.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low); [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  output channels 7..0.
- uio_out  out  8  output channels 15..8.
- uio_oe  out  8  constant 8'hFF.

## Operation
- SCLK, COPI and nCS each pass through a 2-flop synchronizer in the clk domain. Edges are detected on the synchronized signals.
- Transaction framing:
  - Starts on the nCS falling edge, which clears the bit counter and shift register.
  - On each synchronized SCLK rising edge while nCS is low, shift COPI in MSB-first.
  - A frame is 16 bits: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
- Commit happens on the nCS rising edge, and only if all of these hold:
  - exactly 16 bits were received;
  - R/W = 1;
  - address ≤ 0x04.
- Otherwise the frame is discarded with no register change. This covers reads, bad addresses, and short or long frames. No read data is ever returned.
- Register map (all reset to 0x00):
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- PWM generator:
  - A prescaler counts 0..12 and wraps, issuing one tick every 13 clk cycles.
  - On each tick, an 8-bit counter increments, wrapping 255→0.
  - Period = 13×256 = 3328 clk cycles (≈3004.8 Hz at 10 MHz).
  - pwm = 1 if duty == 0xFF; else pwm = 1 when counter < duty.
  - Duty 0x00 gives a constant low. Duty 0x80 gives 50% high.
- Per channel i: out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
- Output mapping: uo_out = out[7:0], uio_out = out[15:8].

## Timing
- Reset: uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF. All registers, counters and synchronizers are 0. nCS synchronizer flops reset to 1 (idle).
- The SCLK high and low phases must each last ≥ 2 clk cycles for reliable sampling. The same applies to the nCS idle time between frames.
- Register update latency: the new value is visible 3 clk cycles after nCS rises at the pins (2 synchronizer cycles + 1 register cycle). Outputs follow combinationally from the registers and the PWM state.
- A duty change takes effect on the next counter compare; the counter is not restarted.
- Reset asserted mid-frame aborts the frame; nothing is committed.
- nCS rising with 0 bits received: no-op. SCLK edges while nCS is high are ignored.

## Test plan
- Reset: hold rst_n = 0 for 5 cycles, release -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Static output: write 0x00←0xF0 and 0x01←0xCC -> uo_out = 0xF0, uio_out = 0xCC.
- Illegal frames:
  - write 0x30←0xAA -> no register changes;
  - read 0x00 (R/W = 0) -> no change;
  - 12-bit frame -> no change.
- PWM 50%: write en_out[7:0] = 0x01, en_pwm[7:0] = 0x01, duty = 0x80 -> uo_out[0] period 3328 ±1 cycles, high time 1664 ±13 cycles.
- PWM extremes, with the channel enabled:
  - duty 0x00 -> uo_out[0] constant 0 over 2 periods;
  - duty 0xFF -> constant 1.
- Mixed enables: en_out = 0xFF, en_pwm = 0x0F, duty 0x40 -> bits 7:4 constant 1; bits 3:0 toggle at ~25% duty.
